// File: rtl/mw_ape.sv
// Signed multiply-accumulate processing element with a small weight bank.
// Runs either as a systolic pass-sum stage or as a local accumulator with saturation.
module mw_ape #(
    parameter int unsigned I_F_BW = 8,
    parameter int unsigned W_BW   = 8,
    parameter int unsigned M_BW   = 16,
    parameter int unsigned AK_BW  = 24,
    parameter int unsigned N_W    = 4,
    parameter int unsigned CW     = 8,
    localparam int unsigned SW    = $clog2(N_W)
) (
    input  logic              en_clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              mode,
    input  logic [CW-1:0]     acc_len,
    input  logic              i_valid,
    input  logic [I_F_BW-1:0] i_fmap,
    input  logic [W_BW-1:0]   i_weight,
    input  logic              w_ld,
    input  logic [SW-1:0]     w_sel,
    input  logic [AK_BW-1:0]  in_pp,
    output logic [I_F_BW-1:0] o_fmap,
    output logic [W_BW-1:0]   o_weight,
    output logic              o_valid,
    output logic [AK_BW-1:0]  o_acc,
    output logic              o_sat
);

    localparam int unsigned SUM_BW = AK_BW + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [I_F_BW-1:0] r_s1_fmap;
    logic [W_BW-1:0]   r_s1_weight;
    logic              r_s1_valid;
    logic [SW-1:0]     r_s1_sel;

    logic [W_BW-1:0]   r_bank [N_W];
    logic [SW-1:0]     r_wr_ptr;

    logic signed [AK_BW-1:0] r_acc;
    logic [CW-1:0]           r_cnt;
    logic [AK_BW-1:0]        r_o_acc;
    logic                    r_o_valid;
    logic                    r_o_sat;

    logic signed [M_BW-1:0]   w_fmap_ext;
    logic signed [M_BW-1:0]   w_wt_ext;
    logic signed [M_BW-1:0]   w_prod;
    logic signed [AK_BW-1:0]  w_prod_ext;
    logic signed [AK_BW-1:0]  w_addend;
    logic signed [SUM_BW-1:0] w_sum;
    logic signed [AK_BW-1:0]  w_sum_sat;
    logic                     w_ovf;
    logic                     w_in_acc;
    logic [CW-1:0]            w_len_m1;
    logic [CW-1:0]            w_cnt_cur;
    logic                     w_last;

    logic signed [AK_BW-1:0] w_acc_nxt;
    logic [CW-1:0]           w_cnt_nxt;
    logic [AK_BW-1:0]        w_o_acc_nxt;
    logic                    w_o_valid_nxt;
    logic                    w_o_sat_nxt;

    // Stage 2 multiply: both operands widened to the product width first
    assign w_fmap_ext = M_BW'($signed(r_s1_fmap));
    assign w_wt_ext   = M_BW'($signed(r_bank[r_s1_sel]));
    assign w_prod     = w_fmap_ext * w_wt_ext;
    assign w_prod_ext = AK_BW'(w_prod);

    // A partial sum only survives while mode stays at local-accumulate
    assign w_in_acc  = (r_state == S_ACC) && mode;
    assign w_addend  = !mode ? $signed(in_pp) : (w_in_acc ? r_acc : AK_BW'(0));
    assign w_len_m1  = (acc_len == '0) ? '0 : acc_len - CW'(1);
    assign w_cnt_cur = w_in_acc ? r_cnt : '0;
    assign w_last    = (w_cnt_cur == w_len_m1);

    // Single saturating adder shared by both modes
    assign w_sum     = SUM_BW'(w_prod_ext) + SUM_BW'(w_addend);
    assign w_ovf     = (w_sum[SUM_BW-1] != w_sum[SUM_BW-2]);
    assign w_sum_sat = !w_ovf           ? w_sum[AK_BW-1:0] :
                       w_sum[SUM_BW-1] ? {1'b1, {(AK_BW-1){1'b0}}} :
                                         {1'b0, {(AK_BW-1){1'b1}}};

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_o_acc_nxt   = r_o_acc;
        w_o_valid_nxt = 1'b0;
        w_o_sat_nxt   = r_o_sat;

        if ((r_state == S_ACC) && !mode) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
        end

        if (r_s1_valid) begin
            if (w_ovf) begin
                w_o_sat_nxt = 1'b1;
            end
            if (!mode || w_last) begin
                w_o_acc_nxt   = w_sum_sat;
                w_o_valid_nxt = 1'b1;
                if (mode) begin
                    w_state_nxt = S_IDLE;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end else begin
                w_state_nxt = S_ACC;
                w_acc_nxt   = w_sum_sat;
                w_cnt_nxt   = w_cnt_cur + CW'(1);
            end
        end

        if (clr) begin
            w_state_nxt   = S_IDLE;
            w_acc_nxt     = '0;
            w_cnt_nxt     = '0;
            w_o_acc_nxt   = '0;
            w_o_valid_nxt = 1'b0;
            w_o_sat_nxt   = 1'b0;
        end
    end

    always_ff @(posedge en_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge en_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_o_acc   <= '0;
            r_o_valid <= 1'b0;
            r_o_sat   <= 1'b0;
        end else begin
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_o_acc   <= w_o_acc_nxt;
            r_o_valid <= w_o_valid_nxt;
            r_o_sat   <= w_o_sat_nxt;
        end
    end

    // Stage 1 capture; fmap/weight forward regardless of valid or clear
    always_ff @(posedge en_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_fmap   <= '0;
            r_s1_weight <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_sel    <= '0;
        end else begin
            r_s1_fmap   <= i_fmap;
            r_s1_weight <= i_weight;
            r_s1_valid  <= i_valid && !clr;
            r_s1_sel    <= w_sel;
        end
    end

    // Weight bank is only cleared by reset, never by clr
    always_ff @(posedge en_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_W); i++) begin
                r_bank[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_ld) begin
            r_bank[r_wr_ptr] <= i_weight;
            r_wr_ptr         <= r_wr_ptr + SW'(1);
        end
    end

    assign o_fmap   = r_s1_fmap;
    assign o_weight = r_s1_weight;
    assign o_valid  = r_o_valid;
    assign o_acc    = r_o_acc;
    assign o_sat    = r_o_sat;

endmodule

// File: tb/tb_mw_ape.sv
// Bench for mw_ape: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_mw_ape;

    localparam int unsigned I_F_BW = 8;
    localparam int unsigned W_BW   = 8;
    localparam int unsigned M_BW   = 16;
    localparam int unsigned AK_BW  = 16;
    localparam int unsigned N_W    = 4;
    localparam int unsigned CW     = 8;
    localparam int unsigned SW     = 2;
    localparam int AMAX = 32767;
    localparam int AMIN = -32768;

    logic              en_clk = 1'b0;
    logic              rst_n  = 1'b1;
    logic              clr    = 1'b0;
    logic              mode   = 1'b0;
    logic [CW-1:0]     acc_len = '0;
    logic              i_valid = 1'b0;
    logic [I_F_BW-1:0] i_fmap  = '0;
    logic [W_BW-1:0]   i_weight = '0;
    logic              w_ld    = 1'b0;
    logic [SW-1:0]     w_sel   = '0;
    logic [AK_BW-1:0]  in_pp   = '0;
    logic [I_F_BW-1:0] o_fmap;
    logic [W_BW-1:0]   o_weight;
    logic              o_valid;
    logic [AK_BW-1:0]  o_acc;
    logic              o_sat;

    always #5 en_clk = ~en_clk;

    mw_ape #(
        .I_F_BW(I_F_BW), .W_BW(W_BW), .M_BW(M_BW),
        .AK_BW(AK_BW), .N_W(N_W), .CW(CW)
    ) dut (
        .en_clk(en_clk), .rst_n(rst_n), .clr(clr), .mode(mode),
        .acc_len(acc_len), .i_valid(i_valid), .i_fmap(i_fmap),
        .i_weight(i_weight), .w_ld(w_ld), .w_sel(w_sel), .in_pp(in_pp),
        .o_fmap(o_fmap), .o_weight(o_weight), .o_valid(o_valid),
        .o_acc(o_acc), .o_sat(o_sat)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model state
    int         m_bank [N_W];
    int         m_ptr;
    bit         m_pend_valid;
    int         m_pend_prod;
    int         m_gsum;
    int         m_gcnt;
    int         m_exp_acc;
    bit         m_exp_valid;
    bit         m_exp_sat;
    logic [7:0] m_exp_fmap;
    logic [7:0] m_exp_weight;

    function automatic int clamp(input int v, output bit hit);
        hit = 1'b0;
        if (v > AMAX) begin hit = 1'b1; return AMAX; end
        if (v < AMIN) begin hit = 1'b1; return AMIN; end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(N_W); i++) m_bank[i] = 0;
        m_ptr = 0; m_pend_valid = 0; m_pend_prod = 0;
        m_gsum = 0; m_gcnt = 0;
        m_exp_acc = 0; m_exp_valid = 0; m_exp_sat = 0;
        m_exp_fmap = '0; m_exp_weight = '0;
    endtask

    // Advance one clock: update model for the cycle just driven, then sample after the edge
    task automatic tick();
        int sum;
        int len;
        bit hit;
        if (mode == 1'b0 && m_gcnt != 0) begin
            m_gcnt = 0;
            m_gsum = 0;
        end
        m_exp_valid = 1'b0;
        if (m_pend_valid) begin
            if (mode == 1'b0) begin
                sum = clamp(m_pend_prod + int'($signed(in_pp)), hit);
                m_exp_sat |= hit;
                m_exp_acc = sum;
                m_exp_valid = 1'b1;
            end else begin
                len = (acc_len == 0) ? 1 : int'(acc_len);
                if (m_gcnt == 0) begin
                    sum = m_pend_prod;
                end else begin
                    sum = clamp(m_gsum + m_pend_prod, hit);
                    m_exp_sat |= hit;
                end
                if (m_gcnt + 1 == len) begin
                    m_exp_acc = sum; m_exp_valid = 1'b1;
                    m_gcnt = 0; m_gsum = 0;
                end else begin
                    m_gsum = sum; m_gcnt++;
                end
            end
        end
        if (w_ld) begin
            m_bank[m_ptr] = int'($signed(i_weight));
            m_ptr = (m_ptr + 1) % int'(N_W);
        end
        m_pend_valid = i_valid;
        if (i_valid) m_pend_prod = int'($signed(i_fmap)) * m_bank[w_sel];
        m_exp_fmap = i_fmap;
        m_exp_weight = i_weight;
        if (clr) begin
            m_exp_acc = 0; m_exp_valid = 0; m_exp_sat = 0;
            m_pend_valid = 0; m_gcnt = 0; m_gsum = 0;
        end
        @(posedge en_clk);
        #1;
    endtask

    task automatic do_reset();
        i_valid = 0; w_ld = 0; clr = 0;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (o_acc !== '0 || o_valid !== 1'b0 || o_sat !== 1'b0 || o_fmap !== '0 || o_weight !== '0) begin
            n_bad++;
            $display("FAIL async_reset: acc=%0d valid=%b sat=%b fmap=%0d weight=%0d, required all zero",
                     o_acc, o_valid, o_sat, o_fmap, o_weight);
        end
        @(posedge en_clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        i_fmap = 8'd9; i_weight = 8'd6;
        do_reset();
        i_fmap = '0; i_weight = '0;
        tick();
        n_total++;
        if (o_valid !== 1'b0 || o_acc !== '0 || o_sat !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: valid=%b acc=%0d sat=%b, required 0/0/0", o_valid, o_acc, o_sat);
        end
    endtask

    task automatic test_pass_sum();
        int wts [4] = '{3, -2, 5, 7};
        mode = 0; acc_len = 8'd1;
        for (int i = 0; i < 4; i++) begin
            w_ld = 1; i_weight = 8'(wts[i]); tick();
        end
        w_ld = 0;
        i_valid = 1; i_fmap = 8'd4; w_sel = 2'd1; in_pp = 16'd100; tick();
        i_valid = 0;
        n_total++;
        if (o_fmap !== 8'd4 || o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL pass_fmap_fwd: fmap=%0d valid=%b, required 4/0", o_fmap, o_valid);
        end
        tick();
        n_total++;
        if (o_valid !== 1'b1 || $signed(o_acc) !== 16'sd92) begin
            n_bad++;
            $display("FAIL pass_sum: valid=%b acc=%0d, required 1/92", o_valid, $signed(o_acc));
        end
        tick();
        n_total++;
        if (o_valid !== 1'b0 || $signed(o_acc) !== 16'sd92) begin
            n_bad++;
            $display("FAIL pass_hold: valid=%b acc=%0d, required 0/92", o_valid, $signed(o_acc));
        end
    endtask

    task automatic test_local_acc();
        int pulses;
        int got;
        int fm [3] = '{1, 2, 3};
        mode = 1; acc_len = 8'd3; w_sel = 2'd0;
        for (int g = 0; g < 2; g++) begin
            pulses = 0; got = 0;
            for (int i = 0; i < 3; i++) begin
                i_valid = 1; i_fmap = (g == 0) ? 8'(fm[i]) : 8'd1; tick();
                if (o_valid === 1'b1) begin pulses++; got = int'($signed(o_acc)); end
            end
            i_valid = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (o_valid === 1'b1) begin pulses++; got = int'($signed(o_acc)); end
            end
            n_total++;
            if (pulses != 1) begin
                n_bad++;
                $display("FAIL local_pulses group%0d: got %0d pulses, required 1", g, pulses);
            end
            n_total++;
            if (got != ((g == 0) ? 18 : 9)) begin
                n_bad++;
                $display("FAIL local_sum group%0d: got %0d, required %0d", g, got, (g == 0) ? 18 : 9);
            end
        end
        acc_len = 8'd0;
        i_valid = 1; i_fmap = 8'd5; tick();
        i_valid = 0; tick();
        n_total++;
        if (o_valid !== 1'b1 || $signed(o_acc) !== 16'sd15) begin
            n_bad++;
            $display("FAIL len_zero: valid=%b acc=%0d, required 1/15", o_valid, $signed(o_acc));
        end
    endtask

    task automatic test_saturation();
        logic [SW-1:0] p;
        mode = 0;
        p = SW'(m_ptr);
        w_ld = 1; i_weight = 8'd127; tick(); w_ld = 0;
        i_valid = 1; i_fmap = 8'd127; w_sel = p; in_pp = 16'h7fff; tick();
        i_valid = 0; tick();
        n_total++;
        if ($signed(o_acc) !== 16'sd32767 || o_sat !== 1'b1 || o_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_pos: acc=%0d sat=%b valid=%b, required 32767/1/1", $signed(o_acc), o_sat, o_valid);
        end
        i_valid = 1; i_fmap = 8'd1; in_pp = 16'd0; tick();
        i_valid = 0; tick();
        n_total++;
        if ($signed(o_acc) !== 16'sd127 || o_sat !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_sticky: acc=%0d sat=%b, required 127/1", $signed(o_acc), o_sat);
        end
        i_valid = 1; i_fmap = 8'h80; in_pp = 16'h8000; tick();
        i_valid = 0; tick();
        n_total++;
        if (o_acc !== 16'h8000 || o_sat !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_neg: acc=%0d sat=%b, required -32768/1", $signed(o_acc), o_sat);
        end
        clr = 1; tick(); clr = 0;
        n_total++;
        if (o_sat !== 1'b0 || o_acc !== '0) begin
            n_bad++;
            $display("FAIL sat_clr: sat=%b acc=%0d, required 0/0", o_sat, $signed(o_acc));
        end
    endtask

    task automatic test_ptr_wrap();
        logic [SW-1:0] p;
        logic [SW-1:0] q;
        mode = 0; in_pp = '0;
        p = SW'(m_ptr);
        for (int i = 1; i <= 5; i++) begin
            w_ld = 1; i_weight = 8'(10 * i); tick();
        end
        w_ld = 0;
        q = SW'(m_ptr);
        i_valid = 1; i_fmap = 8'd1; w_sel = p; tick();
        w_sel = q; tick();
        n_total++;
        if ($signed(o_acc) !== 16'sd50) begin
            n_bad++;
            $display("FAIL ptr_wrap: acc=%0d, required 50", $signed(o_acc));
        end
        w_ld = 1; i_weight = 8'd99; i_fmap = 8'd2; w_sel = q; tick();
        w_ld = 0;
        n_total++;
        if ($signed(o_acc) !== 16'sd20) begin
            n_bad++;
            $display("FAIL ptr_next_entry: acc=%0d, required 20", $signed(o_acc));
        end
        i_fmap = 8'd1; tick();
        i_valid = 0;
        n_total++;
        if ($signed(o_acc) !== 16'sd198) begin
            n_bad++;
            $display("FAIL write_same_cycle: acc=%0d, required 198", $signed(o_acc));
        end
        tick();
        n_total++;
        if ($signed(o_acc) !== 16'sd99) begin
            n_bad++;
            $display("FAIL write_next_beat: acc=%0d, required 99", $signed(o_acc));
        end
    endtask

    task automatic test_abort();
        int pulses;
        int got;
        mode = 1; acc_len = 8'd4; w_sel = 2'd0;
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            i_valid = 1; i_fmap = 8'd1; tick();
            if (o_valid === 1'b1) pulses++;
        end
        do_reset();
        if (o_valid === 1'b1) pulses++;
        mode = 1; acc_len = 8'd4;
        w_ld = 1; i_weight = 8'd3; tick(); w_ld = 0;
        if (o_valid === 1'b1) pulses++;
        n_total++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL abort_reset_pulse: got %0d pulses, required 0", pulses);
        end
        got = 0;
        for (int i = 1; i <= 7; i++) begin
            i_valid = (i <= 4); i_fmap = 8'(i); tick();
            if (o_valid === 1'b1) begin pulses++; got = int'($signed(o_acc)); end
        end
        i_valid = 0;
        n_total++;
        if (pulses != 1 || got != 30) begin
            n_bad++;
            $display("FAIL abort_reset_sum: pulses=%0d sum=%0d, required 1/30", pulses, got);
        end
        pulses = 0; got = 0;
        for (int i = 0; i < 2; i++) begin
            i_valid = 1; i_fmap = 8'd5; tick();
            if (o_valid === 1'b1) pulses++;
        end
        i_valid = 0; tick();
        if (o_valid === 1'b1) pulses++;
        mode = 0; tick();
        if (o_valid === 1'b1) pulses++;
        mode = 1;
        for (int i = 0; i < 7; i++) begin
            i_valid = (i < 4); i_fmap = 8'd1; tick();
            if (o_valid === 1'b1) begin pulses++; got = int'($signed(o_acc)); end
        end
        i_valid = 0;
        n_total++;
        if (pulses != 1 || got != 12) begin
            n_bad++;
            $display("FAIL abort_mode_sum: pulses=%0d sum=%0d, required 1/12", pulses, got);
        end
    endtask

    task automatic test_clr();
        mode = 0; w_sel = 2'd0; in_pp = '0;
        i_valid = 1; i_fmap = 8'd10; tick();
        i_valid = 0; tick();
        n_total++;
        if ($signed(o_acc) !== 16'sd30 || o_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_pre: acc=%0d valid=%b, required 30/1", $signed(o_acc), o_valid);
        end
        i_valid = 1; clr = 1; i_fmap = 8'd7; tick();
        i_valid = 0; clr = 0;
        n_total++;
        if (o_acc !== '0 || o_valid !== 1'b0 || o_sat !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_with_beat: acc=%0d valid=%b sat=%b, required 0/0/0", $signed(o_acc), o_valid, o_sat);
        end
        tick();
        n_total++;
        if (o_valid !== 1'b0 || o_acc !== '0) begin
            n_bad++;
            $display("FAIL clr_beat_dropped: acc=%0d valid=%b, required 0/0", $signed(o_acc), o_valid);
        end
        i_valid = 1; i_fmap = 8'd4; tick();
        i_valid = 0; clr = 1; tick(); clr = 0;
        n_total++;
        if (o_valid !== 1'b0 || o_acc !== '0) begin
            n_bad++;
            $display("FAIL clr_stage2: acc=%0d valid=%b, required 0/0", $signed(o_acc), o_valid);
        end
        in_pp = 16'd1;
        i_valid = 1; i_fmap = 8'd2; tick();
        i_valid = 0; tick();
        n_total++;
        if ($signed(o_acc) !== 16'sd7 || o_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_bank_kept: acc=%0d valid=%b, required 7/1", $signed(o_acc), o_valid);
        end
        clr = 1; tick(); clr = 0;
        in_pp = '0;
        w_ld = 1; i_weight = 8'd11; tick(); w_ld = 0;
        i_valid = 1; i_fmap = 8'd1; w_sel = 2'd1; tick();
        i_valid = 0; tick();
        n_total++;
        if ($signed(o_acc) !== 16'sd11) begin
            n_bad++;
            $display("FAIL clr_ptr_kept: acc=%0d, required 11", $signed(o_acc));
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 30; seg++) begin
            i_valid = 0; w_ld = 0; clr = 1; tick(); clr = 0;
            mode = 1'($urandom_range(0, 1));
            acc_len = CW'($urandom_range(0, 5));
            for (int c = 0; c < 60; c++) begin
                i_valid  = ($urandom_range(0, 9) < 7);
                w_ld     = ($urandom_range(0, 4) == 0);
                clr      = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 29) == 0) mode = ~mode;
                i_fmap   = 8'($urandom);
                i_weight = 8'($urandom);
                w_sel    = 2'($urandom);
                case ($urandom_range(0, 3))
                    0:       in_pp = 16'(AMAX - int'($urandom_range(0, 300)));
                    1:       in_pp = 16'(AMIN + int'($urandom_range(0, 300)));
                    default: in_pp = 16'(int'($urandom_range(0, 8000)) - 4000);
                endcase
                tick();
                n_total++;
                if (o_valid !== m_exp_valid) begin
                    n_bad++;
                    $display("FAIL rnd_valid seg%0d cyc%0d: got %b, required %b", seg, c, o_valid, m_exp_valid);
                end
                n_total++;
                if (o_acc !== AK_BW'(m_exp_acc)) begin
                    n_bad++;
                    $display("FAIL rnd_acc seg%0d cyc%0d: got %0d, required %0d", seg, c, $signed(o_acc), m_exp_acc);
                end
                n_total++;
                if (o_sat !== m_exp_sat) begin
                    n_bad++;
                    $display("FAIL rnd_sat seg%0d cyc%0d: got %b, required %b", seg, c, o_sat, m_exp_sat);
                end
                n_total++;
                if (o_fmap !== m_exp_fmap || o_weight !== m_exp_weight) begin
                    n_bad++;
                    $display("FAIL rnd_fwd seg%0d cyc%0d: got %0d/%0d, required %0d/%0d",
                             seg, c, o_fmap, o_weight, m_exp_fmap, m_exp_weight);
                end
            end
        end
        clr = 0; i_valid = 0; w_ld = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pass_sum();
        test_local_acc();
        test_saturation();
        test_ptr_wrap();
        test_abort();
        test_clr();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
